// File: rtl/dcache_responder_if.sv
// Purpose: bundles the MEM-stage request/response and backing-RAM port of dcache_responder.
// Latency: none, wiring only.
// Backpressure: the cache holds the pipeline through stall; the RAM completes through mem_ack.
// Ports: cpu_addr/cpu_wdata/cpu_we/cpu_re in; hit/cache_out/stall out;
//        mem_req/mem_we/mem_addr/mem_wdata out; mem_rdata/mem_ack in (cache view).
interface dcache_responder_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_we;
  logic              cpu_re;
  logic              hit;
  logic [DATA_W-1:0] cache_out;
  logic              stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              mem_ack;

  // Pipeline and backing RAM side.
  modport master (
    output cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, mem_ack,
    input  hit, cache_out, stall, mem_req, mem_we, mem_addr, mem_wdata
  );

  // Cache side.
  modport slave (
    input  cpu_addr, cpu_wdata, cpu_we, cpu_re, mem_rdata, mem_ack,
    output hit, cache_out, stall, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_responder.sv
// Purpose: direct-mapped, one-word-line, write-through/no-write-allocate data cache for the MEM stage.
// Latency: load hit 0 cycles; miss/store 1 issue + RAM latency + 1 DONE cycle.
// Backpressure: stall holds the MEM-stage inputs; mem_req is held until a one-cycle mem_ack.
// Ports: clock, reset (sync, active-high); bus (slave modport) carries the cpu_* request,
//        hit/cache_out/stall response and the registered mem_* RAM port.
module dcache_responder #(
  parameter int INDEX_BITS = 4,
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16
) (
  input  logic                clock,
  input  logic                reset,
  dcache_responder_if.slave   bus
);
  localparam int LINES = 1 << INDEX_BITS;
  localparam int TAG_W = ADDR_W - INDEX_BITS;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] REFILL = 2'd1;
  localparam logic [1:0] WRITE  = 2'd2;
  localparam logic [1:0] DONE   = 2'd3;

  logic [1:0]        state;
  logic [LINES-1:0]  valid_q;
  logic [TAG_W-1:0]  tag_q  [LINES];
  logic [DATA_W-1:0] data_q [LINES];

  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;

  logic [INDEX_BITS-1:0] cpu_idx;
  logic [TAG_W-1:0]      cpu_tag;
  logic [INDEX_BITS-1:0] mem_idx;
  logic [TAG_W-1:0]      mem_tag;
  logic                  lookup_hit;
  logic                  mem_line_match;
  logic                  is_store;
  logic                  is_load;
  logic                  refill_fill;
  logic                  write_update;

  assign cpu_idx = bus.cpu_addr[INDEX_BITS-1:0];
  assign cpu_tag = bus.cpu_addr[ADDR_W-1:INDEX_BITS];
  assign mem_idx = mem_addr_q[INDEX_BITS-1:0];
  assign mem_tag = mem_addr_q[ADDR_W-1:INDEX_BITS];

  // A store takes priority when both strobes are raised together.
  assign is_store = bus.cpu_we;
  assign is_load  = bus.cpu_re & ~bus.cpu_we;

  assign lookup_hit     = valid_q[cpu_idx] && (tag_q[cpu_idx] == cpu_tag);
  assign mem_line_match = valid_q[mem_idx] && (tag_q[mem_idx] == mem_tag);

  // Array updates are keyed off the registered RAM address; a reset in the
  // same cycle as the ack abandons the operation without touching the line.
  assign refill_fill  = !reset && (state == REFILL) && bus.mem_ack;
  assign write_update = !reset && (state == WRITE) && bus.mem_ack && mem_line_match;

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.cache_out = data_q[cpu_idx];

  always_comb begin
    bus.hit   = 1'b0;
    bus.stall = 1'b0;
    if (!reset) begin
      case (state)
        IDLE: begin
          if (is_store) begin
            bus.stall = 1'b1;
          end else if (is_load) begin
            bus.hit   = lookup_hit;
            bus.stall = ~lookup_hit;
          end
        end
        REFILL, WRITE: bus.stall = 1'b1;
        // Inputs are still held, so the freshly filled line is what cpu_idx selects.
        DONE:    bus.hit = is_load;
        default: bus.stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (is_store) begin
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b1;
            mem_addr_q  <= bus.cpu_addr;
            mem_wdata_q <= bus.cpu_wdata;
            state       <= WRITE;
          end else if (is_load && !lookup_hit) begin
            mem_req_q  <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= bus.cpu_addr;
            state      <= REFILL;
          end
        end
        REFILL: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            state     <= DONE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            state     <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Only the valid bits are reset; tag/data contents are don't-care until filled.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= '0;
    end else if (refill_fill) begin
      valid_q[mem_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (refill_fill) begin
      tag_q[mem_idx]  <= mem_tag;
      data_q[mem_idx] <= bus.mem_rdata;
    end else if (write_update) begin
      data_q[mem_idx] <= mem_wdata_q;
    end
  end
endmodule

// File: tb/tb_dcache_responder.sv
// Purpose: directed, table-driven check of dcache_responder hits, refills, write-through and reset abort.
// Latency: the bench models RAM latency per vector (ack on the (lat+1)th cycle mem_req is seen).
// Backpressure: each access is held until stall drops, with a bounded cycle budget.
module tb_dcache_responder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clock = ~clock;

  dcache_responder_if #(.ADDR_W(16), .DATA_W(16)) bus ();

  dcache_responder #(.INDEX_BITS(4), .ADDR_W(16), .DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic        we;
    logic        re;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] rdata;
    int          exp_stall;
    logic        exp_issued;
    logic        exp_mem_we;
    logic        exp_hit;
    logic [15:0] exp_out;
  } vec_t;

  vec_t vecs [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Present one access, play the RAM, and compare what was observed.
  task automatic run_vec(input vec_t v, input string nm);
    int          stall_cnt = 0;
    int          req_cnt   = 0;
    int          first_req = -1;
    logic        done      = 1'b0;
    logic        seen_we   = 1'b0;
    logic [15:0] seen_addr = '0;
    logic [15:0] seen_wd   = '0;
    logic        fhit      = 1'b0;
    logic [15:0] fout      = '0;
    logic        freq      = 1'b0;
    bus.cpu_we    = v.we;
    bus.cpu_re    = v.re;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wdata;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clock);
      if (!bus.stall) begin
        done = 1'b1;
        fhit = bus.hit;
        fout = bus.cache_out;
        freq = bus.mem_req;
      end else begin
        stall_cnt++;
        if (bus.mem_req) begin
          if (first_req < 0) begin
            first_req = cyc;
            seen_we   = bus.mem_we;
            seen_addr = bus.mem_addr;
            seen_wd   = bus.mem_wdata;
          end
          req_cnt++;
          if (req_cnt == v.lat + 1) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = v.rdata;
          end
        end
        @(posedge clock);
        #1;
        bus.mem_ack = 1'b0;
      end
    end
    check({nm, "_finished"}, {31'd0, done}, 32'd1);
    check({nm, "_stall_cycles"}, stall_cnt, v.exp_stall);
    check({nm, "_issued"}, {31'd0, first_req >= 0}, {31'd0, v.exp_issued});
    check({nm, "_hit"}, {31'd0, fhit}, {31'd0, v.exp_hit});
    check({nm, "_req_low_at_end"}, {31'd0, freq}, 32'd0);
    if (v.exp_issued) begin
      check({nm, "_req_delay"}, first_req, 1);
      check({nm, "_mem_we"}, {31'd0, seen_we}, {31'd0, v.exp_mem_we});
      check({nm, "_mem_addr"}, {16'd0, seen_addr}, {16'd0, v.addr});
      if (v.exp_mem_we) check({nm, "_mem_wdata"}, {16'd0, seen_wd}, {16'd0, v.wdata});
    end
    if (v.exp_hit) check({nm, "_cache_out"}, {16'd0, fout}, {16'd0, v.exp_out});
    @(posedge clock);
    #1;
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
  endtask

  initial begin
    vec_t v;
    //            we    re    addr      wdata     lat rdata     stall iss   mwe   hit   out
    vecs[0]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 3, 16'hBEEF, 5, 1'b1, 1'b0, 1'b1, 16'hBEEF}; // cold load
    vecs[1]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'hBEEF}; // repeat hit
    vecs[2]  = '{1'b1, 1'b0, 16'h0013, 16'h1234, 2, 16'h0000, 4, 1'b1, 1'b1, 1'b0, 16'h0000}; // store resident
    vecs[3]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'h1234}; // updated line
    vecs[4]  = '{1'b1, 1'b0, 16'h0023, 16'h5555, 1, 16'h0000, 3, 1'b1, 1'b1, 1'b0, 16'h0000}; // no allocate
    vecs[5]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'h1234}; // untouched
    vecs[6]  = '{1'b0, 1'b1, 16'h0023, 16'h0000, 2, 16'h7777, 4, 1'b1, 1'b0, 1'b1, 16'h7777}; // conflict refill
    vecs[7]  = '{1'b0, 1'b1, 16'h0023, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'h7777};
    vecs[8]  = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'h1234, 2, 1'b1, 1'b0, 1'b1, 16'h1234}; // evicted, refill
    vecs[9]  = '{1'b1, 1'b1, 16'h0013, 16'hABCD, 1, 16'hDEAD, 3, 1'b1, 1'b1, 1'b0, 16'h0000}; // we+re = store
    vecs[10] = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b1, 16'hABCD};
    vecs[11] = '{1'b0, 1'b0, 16'h0013, 16'h0000, 0, 16'h0000, 0, 1'b0, 1'b0, 1'b0, 16'h0000}; // idle
    vecs[12] = '{1'b0, 1'b1, 16'h0005, 16'h0000, 0, 16'h0F0F, 2, 1'b1, 1'b0, 1'b1, 16'h0F0F}; // zero RAM wait

    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b1;
    bus.cpu_addr  = 16'h0013;
    bus.cpu_wdata = 16'h0000;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 16'h0000;

    // Reset state, with a load request present to show hit/stall are forced low.
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_hit", {31'd0, bus.hit}, 32'd0);
    check("rst_stall", {31'd0, bus.stall}, 32'd0);
    check("rst_mem_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_mem_addr", {16'd0, bus.mem_addr}, 32'd0);
    check("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
    @(posedge clock);
    #1;
    reset      = 1'b0;
    bus.cpu_re = 1'b0;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], $sformatf("v%0d", i));

    // Reset in the middle of a refill, followed by a late ack.
    bus.cpu_re   = 1'b1;
    bus.cpu_addr = 16'h0044;
    @(negedge clock);
    check("abort_issue_stall", {31'd0, bus.stall}, 32'd1);
    check("abort_issue_req", {31'd0, bus.mem_req}, 32'd0);
    @(negedge clock);
    check("abort_refill_req", {31'd0, bus.mem_req}, 32'd1);
    check("abort_refill_addr", {16'd0, bus.mem_addr}, 32'h0044);
    @(posedge clock);
    #1;
    reset = 1'b1;
    @(negedge clock);
    check("abort_rst_hit", {31'd0, bus.hit}, 32'd0);
    check("abort_rst_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    reset         = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 16'h9999;
    @(negedge clock);
    check("abort_req_cleared", {31'd0, bus.mem_req}, 32'd0);
    check("abort_idle_stall", {31'd0, bus.stall}, 32'd0);
    @(posedge clock);
    #1;
    bus.mem_ack = 1'b0;
    @(negedge clock);
    check("late_ack_req", {31'd0, bus.mem_req}, 32'd0);
    @(posedge clock);
    #1;
    // The aborted line must still be invalid, and the earlier one gone after reset.
    v = '{1'b0, 1'b1, 16'h0044, 16'h0000, 1, 16'h4444, 3, 1'b1, 1'b0, 1'b1, 16'h4444};
    run_vec(v, "after_abort");
    v = '{1'b0, 1'b1, 16'h0013, 16'h0000, 0, 16'hABCD, 2, 1'b1, 1'b0, 1'b1, 16'hABCD};
    run_vec(v, "after_reset_cold");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
